// File: rtl/task_graph_sequencer_if.sv
// Bus between host/task_mapper side and task_graph_sequencer: slot writes,
// commits, pause, and the paced adjacency-matrix stream.
interface task_graph_sequencer_if #(
  parameter int NUM_V    = 4,
  parameter int NUM_APPS = 2,
  parameter int DATA_W   = 32
);
  localparam int IDX_W  = $clog2(NUM_V);
  localparam int SLOT_W = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;

  logic                wr_en;
  logic [SLOT_W-1:0]   wr_slot;
  logic [IDX_W-1:0]    wr_row;
  logic [IDX_W-1:0]    wr_col;
  logic [DATA_W-1:0]   wr_data;
  logic                commit;
  logic [SLOT_W-1:0]   commit_slot;
  logic                pause;

  logic [DATA_W-1:0]   task_array;
  logic                root_task;
  logic [IDX_W-1:0]    row;
  logic [IDX_W-1:0]    col;
  logic                app_end;
  logic                busy;
  logic [SLOT_W-1:0]   active_slot;
  logic [NUM_APPS-1:0] slot_pending;
  logic                wr_err;
  logic [15:0]         apps_done;

  modport master (
    output wr_en, wr_slot, wr_row, wr_col, wr_data, commit, commit_slot, pause,
    input  task_array, root_task, row, col, app_end, busy, active_slot,
           slot_pending, wr_err, apps_done
  );

  modport slave (
    input  wr_en, wr_slot, wr_row, wr_col, wr_data, commit, commit_slot, pause,
    output task_array, root_task, row, col, app_end, busy, active_slot,
           slot_pending, wr_err, apps_done
  );
endinterface

// File: rtl/task_graph_sequencer.sv
// Holds NUM_APPS task-graph matrices, round-robins over committed slots and
// streams each one row-major to task_mapper with fixed per-entry pacing.
module task_graph_sequencer #(
  parameter int NUM_V     = 4,
  parameter int NUM_APPS  = 2,
  parameter int DATA_W    = 32,
  parameter int ENTRY_CYC = 2
) (
  input logic                   clk,
  input logic                   rst,
  task_graph_sequencer_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_V);
  localparam int SLOT_W = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;
  localparam int CNT_W  = (ENTRY_CYC > 1) ? $clog2(ENTRY_CYC) : 1;
  localparam int unsigned NUM_APPS_U = NUM_APPS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_V - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ENTRY_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_TAIL, S_END, S_POST} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d, last_q, last_d;
  logic [NUM_APPS-1:0] pending_q, pending_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                root_q, root_d, root_seen_q, root_seen_d;
  logic [15:0]         done_q, done_d;
  logic                wr_err_q, wr_err_d;

  logic [DATA_W-1:0]   mem [NUM_APPS][NUM_V][NUM_V];

  logic                busy, wr_block;
  logic                grant_found;
  logic [SLOT_W-1:0]   grant_slot, cand;
  logic [IDX_W-1:0]    nxt_row, nxt_col;
  logic [DATA_W-1:0]   rd_first, rd_next;

  assign busy     = (state_q != S_IDLE);
  assign wr_block = busy && (bus.wr_slot == slot_q);

  always_ff @(posedge clk) begin
    if (bus.wr_en && !wr_block) mem[bus.wr_slot][bus.wr_row][bus.wr_col] <= bus.wr_data;
  end

  // Search starts just after the last-served slot and wraps around.
  always_comb begin
    grant_found = 1'b0;
    grant_slot  = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_APPS_U; i++) begin
      cand = SLOT_W'((32'(last_q) + i) % NUM_APPS_U);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_slot  = cand;
      end
    end
  end

  // Entry data is read one step ahead so each entry is registered on the
  // same edge that advances the index: no bubble even at ENTRY_CYC=1.
  assign nxt_col  = (col_q == LAST_IDX) ? '0 : col_q + 1'b1;
  assign nxt_row  = (col_q == LAST_IDX) ? row_q + 1'b1 : row_q;
  assign rd_first = mem[grant_slot][0][0];
  assign rd_next  = mem[slot_q][nxt_row][nxt_col];

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    last_d      = last_q;
    data_d      = data_q;
    root_d      = root_q;
    root_seen_d = root_seen_q;
    done_d      = done_q;
    pending_d   = pending_q;
    wr_err_d    = bus.wr_en && wr_block;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d     = S_STREAM;
          slot_d      = grant_slot;
          last_d      = grant_slot;
          row_d       = '0;
          col_d       = '0;
          cnt_d       = '0;
          data_d      = rd_first;
          root_d      = |rd_first;
          root_seen_d = |rd_first;
          pending_d[grant_slot] = 1'b0;
        end
      end
      S_STREAM: begin
        if (!bus.pause) begin
          if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + 1'b1;
          end else if (row_q == LAST_IDX && col_q == LAST_IDX) begin
            state_d = S_TAIL;
          end else begin
            cnt_d       = '0;
            row_d       = nxt_row;
            col_d       = nxt_col;
            data_d      = rd_next;
            root_d      = (|rd_next) && !root_seen_q;
            root_seen_d = root_seen_q || (|rd_next);
          end
        end
      end
      S_TAIL: begin
        state_d = S_END;
        done_d  = done_q + 16'd1;
      end
      S_END:   state_d = S_POST;
      S_POST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A commit landing on the grant edge overrides the clear above.
    if (bus.commit) pending_d[bus.commit_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      slot_q      <= '0;
      last_q      <= SLOT_W'(NUM_APPS - 1);
      pending_q   <= '0;
      data_q      <= '0;
      root_q      <= 1'b0;
      root_seen_q <= 1'b0;
      done_q      <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      last_q      <= last_d;
      pending_q   <= pending_d;
      data_q      <= data_d;
      root_q      <= root_d;
      root_seen_q <= root_seen_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign bus.task_array   = (state_q == S_STREAM) ? data_q : '0;
  assign bus.root_task    = (state_q == S_STREAM) && root_q;
  assign bus.row          = row_q;
  assign bus.col          = col_q;
  assign bus.app_end      = (state_q == S_END);
  assign bus.busy         = busy;
  assign bus.active_slot  = slot_q;
  assign bus.slot_pending = pending_q;
  assign bus.wr_err       = wr_err_q;
  assign bus.apps_done    = done_q;
endmodule

// File: tb/tb_task_graph_sequencer.sv
// Scoreboard bench for task_graph_sequencer: each commit queues the expected
// application image, and the checker compares every streamed cycle against it.
module tb_task_graph_sequencer;
  localparam int NV = 4;
  localparam int NA = 2;
  localparam int DW = 32;
  localparam int EC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  task_graph_sequencer_if #(.NUM_V(NV), .NUM_APPS(NA), .DATA_W(DW)) bus();

  task_graph_sequencer #(
    .NUM_V(NV), .NUM_APPS(NA), .DATA_W(DW), .ENTRY_CYC(EC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    int                     slot;
    int                     pe;
    int                     pn;
    logic [NV*NV*DW-1:0]    m;
  } app_t;

  app_t          exp_q[$];
  logic [DW-1:0] model [NA][NV*NV];
  int            n_cmp = 0;
  int            n_err = 0;
  int            exp_done = 0;
  int            last_wait = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic put(input int s, input int e, input logic [DW-1:0] d,
                     input bit drop, input bit chk);
    bus.wr_en   = 1'b1;
    bus.wr_slot = 1'(s);
    bus.wr_row  = 2'(e / NV);
    bus.wr_col  = 2'(e % NV);
    bus.wr_data = d;
    @(negedge clk);
    if (chk) check("wr_err", 64'(bus.wr_err), 64'(drop));
    bus.wr_en = 1'b0;
    if (!drop) model[s][e] = d;
  endtask

  task automatic load_slot(input int s, input logic [DW-1:0] g [NV*NV]);
    for (int e = 0; e < NV*NV; e++) put(s, e, g[e], 1'b0, 1'b0);
  endtask

  task automatic commit_app(input int s, input bit push, input int pe, input int pn);
    app_t a;
    bus.commit      = 1'b1;
    bus.commit_slot = 1'(s);
    if (push) begin
      a.slot = s;
      a.pe   = pe;
      a.pn   = pn;
      a.m    = '0;
      for (int e = 0; e < NV*NV; e++) a.m[e*DW +: DW] = model[s][e];
      exp_q.push_back(a);
    end
    @(negedge clk);
    bus.commit = 1'b0;
  endtask

  task automatic check_apps(input int n);
    app_t          a;
    int            w, fr, hold;
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (bus.busy !== 1'b1 && w < 200) begin
        @(negedge clk);
        w++;
      end
      last_wait = w;
      if (bus.busy !== 1'b1) begin
        check("grant_timeout", 64'(bus.busy), 64'(1));
        return;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 64'(exp_q.size()), 64'(1));
        return;
      end
      a = exp_q.pop_front();
      check("active_slot", 64'(bus.active_slot), 64'(a.slot));
      fr = -1;
      for (int e = 0; e < NV*NV; e++)
        if (fr < 0 && a.m[e*DW +: DW] != '0) fr = e;
      for (int e = 0; e < NV*NV; e++) begin
        d    = a.m[e*DW +: DW];
        hold = EC + ((e == a.pe) ? a.pn : 0);
        for (int h = 0; h < hold; h++) begin
          if (e == a.pe && h == 0)    bus.pause = 1'b1;
          if (e == a.pe && h == a.pn) bus.pause = 1'b0;
          check("entry",
                64'({bus.app_end, bus.busy, bus.row, bus.col, bus.root_task, bus.task_array}),
                64'({1'b0, 1'b1, 2'(e / NV), 2'(e % NV), (e == fr), d}));
          @(negedge clk);
        end
      end
      check("tail",
            64'({bus.app_end, bus.busy, bus.row, bus.col, bus.root_task, bus.task_array}),
            64'({1'b0, 1'b1, 2'(NV-1), 2'(NV-1), 1'b0, 32'h0}));
      @(negedge clk);
      exp_done++;
      check("app_end", 64'({bus.app_end, bus.busy}), 64'(2'b11));
      check("apps_done", 64'(bus.apps_done), 64'(exp_done));
      @(negedge clk);
      check("post", 64'({bus.app_end, bus.busy, bus.root_task, bus.task_array}),
            64'({1'b0, 1'b1, 1'b0, 32'h0}));
      @(negedge clk);
      check("idle_after_post", 64'(bus.busy), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] g1 [NV*NV];
    logic [DW-1:0] gz [NV*NV];
    logic [DW-1:0] gr [NV*NV];
    int            w;
    logic          seen;

    g1 = '{32'd0, 32'd0, 32'd0, 32'd7,
           32'd0, 32'd0, 32'd6, 32'd0,
           32'd0, 32'd6, 32'd0, 32'd5,
           32'd7, 32'd0, 32'd5, 32'd0};
    for (int e = 0; e < NV*NV; e++) begin
      gz[e] = '0;
      gr[e] = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(1, 255)) : '0;
    end

    bus.wr_en = 1'b0; bus.wr_slot = '0; bus.wr_row = '0; bus.wr_col = '0;
    bus.wr_data = '0; bus.commit = 1'b0; bus.commit_slot = '0; bus.pause = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state",
          64'({bus.busy, bus.app_end, bus.root_task, bus.wr_err, bus.task_array, bus.row,
               bus.col, bus.active_slot, bus.slot_pending, bus.apps_done}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Reference graph: root at (0,3), grant one edge after pending.
    load_slot(0, g1);
    commit_app(0, 1'b1, -1, 0);
    check("pending_visible", 64'(bus.slot_pending), 64'(2'b01));
    check_apps(1);
    check("grant_latency", 64'(last_wait), 64'(1));

    // All-zero graph: no root at all.
    load_slot(1, gz);
    commit_app(1, 1'b1, -1, 0);
    check_apps(1);

    // Commit on the grant edge keeps the slot pending.
    commit_app(0, 1'b1, -1, 0);
    commit_app(0, 1'b1, -1, 0);
    check("commit_wins", 64'(bus.slot_pending), 64'(2'b01));
    check_apps(2);

    // Round-robin with re-commit of the active slot: 0, 1, 0.
    load_slot(1, gr);
    fork
      check_apps(3);
      begin
        commit_app(0, 1'b1, -1, 0);
        commit_app(1, 1'b1, -1, 0);
        repeat (10) @(negedge clk);
        commit_app(0, 1'b1, -1, 0);
      end
    join

    // Write to the active slot is dropped; write to the other slot lands.
    fork
      check_apps(3);
      begin
        commit_app(0, 1'b1, -1, 0);
        repeat (5) @(negedge clk);
        put(0, 5, 32'hDEAD, 1'b1, 1'b1);
        put(1, 9, 32'h55, 1'b0, 1'b1);
        commit_app(1, 1'b1, -1, 0);
        commit_app(0, 1'b1, -1, 0);
      end
    join

    // Pause for 5 cycles on entry (1,2).
    commit_app(0, 1'b1, 6, 5);
    check_apps(1);

    // Reset at stream cycle 10 abandons the application.
    commit_app(0, 1'b0, -1, 0);
    commit_app(1, 1'b0, -1, 0);
    w = 0;
    while (bus.busy !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("rst_test_started", 64'(bus.busy), 64'(1));
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset",
          64'({bus.busy, bus.app_end, bus.root_task, bus.wr_err, bus.task_array, bus.row,
               bus.col, bus.active_slot, bus.slot_pending, bus.apps_done}), 64'(0));
    rst = 1'b0;
    exp_done = 0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | bus.busy | bus.app_end;
    end
    check("abandoned_quiet", 64'(seen), 64'(0));
    commit_app(0, 1'b1, -1, 0);
    check_apps(1);
    check("regrant_latency", 64'(last_wait), 64'(1));

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
